// File: rtl/half_predict_sequencer.sv
// Control FSM that steps one shared half-float MAC through both MNIST layers and writes results back.
// Define ARGMAX_EN to add a running argmax over the output-layer results.
module half_predict_sequencer #(
  parameter int LAYER1_NEURONS = 784,
  parameter int LAYER2_NEURONS = 50,
  parameter int OUTPUT_NODES   = 10,
  localparam int IW = $clog2(LAYER1_NEURONS),
  localparam int NW = $clog2(LAYER2_NEURONS),
  localparam int OW = $clog2(OUTPUT_NODES)
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          start_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          layer_o,
  output logic [IW-1:0] in_idx_o,
  output logic [NW-1:0] neu_idx_o,
  output logic          mac_clr_o,
  output logic          mac_en_o,
  output logic          mac_last_o,
  output logic          bias_en_o,
  input  logic          acc_valid_i,
  input  logic [15:0]   acc_result_i,
  output logic          wr_en_o,
  output logic [NW-1:0] wr_idx_o,
  output logic [15:0]   wr_data_o,
  output logic [OW-1:0] argmax_o,
  output logic          argmax_vld_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_MAC, S_BIAS, S_DRAIN, S_WRITE, S_DONE
  } state_t;

  state_t        state_q;
  logic          busy_q, done_q, layer_q;
  logic [IW-1:0] inIdx_q;
  logic [NW-1:0] neuIdx_q;
  logic          macClr_q, macEn_q, macLast_q, biasEn_q, wrEn_q;
  logic [NW-1:0] wrIdx_q;
  logic [15:0]   wrData_q;

  logic [IW-1:0] inIdx_d, lastIn_d;
  logic [NW-1:0] neuIdx_d, lastNeu_d;
  logic [15:0]   wrData_d;

  // Hidden layer applies ReLU by sign bit only, so -0 and negative NaN also clamp to zero.
  always_comb begin
    lastIn_d  = layer_q ? IW'(LAYER2_NEURONS - 1) : IW'(LAYER1_NEURONS - 1);
    lastNeu_d = layer_q ? NW'(OUTPUT_NODES - 1)   : NW'(LAYER2_NEURONS - 1);
    inIdx_d   = inIdx_q + IW'(1);
    neuIdx_d  = neuIdx_q + NW'(1);
    wrData_d  = (!layer_q && acc_result_i[15]) ? 16'h0000 : acc_result_i;
  end

`ifdef ARGMAX_EN
  logic [15:0]   maxKey_q;
  logic [OW-1:0] runIdx_q, argmax_q;
  logic          argmaxVld_q;
  logic [15:0]   yKey_d;
  logic          takeMax_d;

  // Sign-magnitude half floats mapped to an unsigned key that orders like the real values.
  always_comb begin
    yKey_d    = wrData_q[15] ? ~wrData_q : (wrData_q ^ 16'h8000);
    takeMax_d = (neuIdx_q == '0) || (yKey_d > maxKey_q);
  end

  assign argmax_o     = argmax_q;
  assign argmax_vld_o = argmaxVld_q;
`else
  assign argmax_o     = '0;
  assign argmax_vld_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      layer_q   <= 1'b0;
      inIdx_q   <= '0;
      neuIdx_q  <= '0;
      macClr_q  <= 1'b0;
      macEn_q   <= 1'b0;
      macLast_q <= 1'b0;
      biasEn_q  <= 1'b0;
      wrEn_q    <= 1'b0;
      wrIdx_q   <= '0;
      wrData_q  <= '0;
`ifdef ARGMAX_EN
      maxKey_q    <= '0;
      runIdx_q    <= '0;
      argmax_q    <= '0;
      argmaxVld_q <= 1'b0;
`endif
    end else begin
      macClr_q  <= 1'b0;
      macEn_q   <= 1'b0;
      macLast_q <= 1'b0;
      biasEn_q  <= 1'b0;
      wrEn_q    <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_q  <= S_CLEAR;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            layer_q  <= 1'b0;
            neuIdx_q <= '0;
            inIdx_q  <= '0;
            macClr_q <= 1'b1;
`ifdef ARGMAX_EN
            argmax_q    <= '0;
            argmaxVld_q <= 1'b0;
`endif
          end
        end
        S_CLEAR: begin
          state_q   <= S_MAC;
          macEn_q   <= 1'b1;
          macLast_q <= (lastIn_d == '0);
        end
        S_MAC: begin
          if (inIdx_q == lastIn_d) begin
            state_q  <= S_BIAS;
            biasEn_q <= 1'b1;
            inIdx_q  <= '0;
          end else begin
            inIdx_q   <= inIdx_d;
            macEn_q   <= 1'b1;
            macLast_q <= (inIdx_d == lastIn_d);
          end
        end
        S_BIAS: state_q <= S_DRAIN;
        S_DRAIN: begin
          if (acc_valid_i) begin
            state_q  <= S_WRITE;
            wrEn_q   <= 1'b1;
            wrIdx_q  <= neuIdx_q;
            wrData_q <= wrData_d;
          end
        end
        S_WRITE: begin
`ifdef ARGMAX_EN
          if (layer_q && takeMax_d) begin
            maxKey_q <= yKey_d;
            runIdx_q <= neuIdx_q[OW-1:0];
          end
`endif
          if (neuIdx_q != lastNeu_d) begin
            state_q  <= S_CLEAR;
            neuIdx_q <= neuIdx_d;
            macClr_q <= 1'b1;
          end else if (!layer_q) begin
            state_q  <= S_CLEAR;
            layer_q  <= 1'b1;
            neuIdx_q <= '0;
            macClr_q <= 1'b1;
          end else begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
`ifdef ARGMAX_EN
            argmax_q    <= takeMax_d ? neuIdx_q[OW-1:0] : runIdx_q;
            argmaxVld_q <= 1'b1;
`endif
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign layer_o    = layer_q;
  assign in_idx_o   = inIdx_q;
  assign neu_idx_o  = neuIdx_q;
  assign mac_clr_o  = macClr_q;
  assign mac_en_o   = macEn_q;
  assign mac_last_o = macLast_q;
  assign bias_en_o  = biasEn_q;
  assign wr_en_o    = wrEn_q;
  assign wr_idx_o   = wrIdx_q;
  assign wr_data_o  = wrData_q;

endmodule

// File: tb/tb_half_predict_sequencer.sv
// Scoreboard bench for half_predict_sequencer: a bench-side MAC responder pushes expected write-backs.
// Argmax expectations follow the ARGMAX_EN define of the build.
module tb_half_predict_sequencer;

  logic        clk, rstn, start, accValid;
  logic [15:0] accResult;
  logic        busy, done, layer, macClr, macEn, macLast, biasEn, wrEn, argmaxVld;
  logic [9:0]  inIdx;
  logic [5:0]  neuIdx, wrIdx;
  logic [15:0] wrData;
  logic [3:0]  argmax;

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct packed {
    logic        layer;
    logic [5:0]  idx;
    logic [15:0] data;
  } exp_t;

  exp_t expQ[$];
  int   pending, respDelay, expNeu, expLayer;
  bit   spurious;

  half_predict_sequencer dut (
    .clk_i(clk), .rstn_i(rstn), .start_i(start),
    .busy_o(busy), .done_o(done), .layer_o(layer),
    .in_idx_o(inIdx), .neu_idx_o(neuIdx),
    .mac_clr_o(macClr), .mac_en_o(macEn), .mac_last_o(macLast), .bias_en_o(biasEn),
    .acc_valid_i(accValid), .acc_result_i(accResult),
    .wr_en_o(wrEn), .wr_idx_o(wrIdx), .wr_data_o(wrData),
    .argmax_o(argmax), .argmax_vld_o(argmaxVld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] resultFor(int lay, int idx);
    logic [15:0] r;
    if (lay == 0) begin
      case (idx)
        0: r = 16'hBC00;
        1: r = 16'h3C00;
        2: r = 16'h8000;
        3: r = 16'hFE00;
        4: r = 16'h7E00;
        5: r = 16'h0001;
        default: r = 16'($urandom);
      endcase
    end else begin
      case (idx)
        0: r = 16'hC000;
        1: r = 16'h3800;
        2: r = 16'h4200;
        3: r = 16'h4200;
        4: r = 16'hBC00;
        default: r = 16'h0000;
      endcase
    end
    return r;
  endfunction

  function automatic logic [50:0] allOut();
    return {busy, done, layer, inIdx, neuIdx, macClr, macEn, macLast, biasEn,
            wrEn, wrIdx, wrData, argmax, argmaxVld};
  endfunction

  // Stand-in for the MAC unit: result arrives respDelay cycles after bias_en, expectation queued then.
  task automatic respond();
    logic [15:0] r;
    exp_t e;
    accValid = 1'b0;
    if (pending > 0) begin
      pending--;
      if (pending == 0) begin
        r = resultFor(expLayer, expNeu);
        accValid  = 1'b1;
        accResult = r;
        e.layer = 1'(expLayer);
        e.idx   = 6'(expNeu);
        e.data  = (expLayer == 0 && r[15]) ? 16'h0000 : r;
        expQ.push_back(e);
        expNeu++;
        if (expLayer == 0 && expNeu == 50) begin
          expLayer = 1;
          expNeu   = 0;
        end
      end
    end else if (spurious && macEn && inIdx == 10'd100) begin
      accValid  = 1'b1;
      accResult = 16'hFFFF;
    end
    if (biasEn) pending = respDelay;
  endtask

  task automatic doReset();
    rstn = 1'b0; start = 1'b0; accValid = 1'b0; accResult = 16'h0000;
    pending = 0; expNeu = 0; expLayer = 0; spurious = 1'b0;
    expQ.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bit found;
    doReset();
    testsRun++;
    if (allOut() !== 51'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_state: outputs=%h required=0", allOut());
    end
    respDelay = 2;
    start = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 8000 && !found; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (macEn && !layer && neuIdx == 6'd7 && inIdx == 10'd400) found = 1'b1;
      else respond();
    end
    testsRun++;
    if (!found) begin
      testsFailed++;
      $display("[TB] FAIL reset_reach_neuron7: got found=%0d required 1", found);
    end
    rstn = 1'b0;
    accValid = 1'b0;
    #1;
    testsRun++;
    if (allOut() !== 51'd0) begin
      testsFailed++;
      $display("[TB] FAIL midrun_reset_outputs: outputs=%h required=0", allOut());
    end
    repeat (2) begin
      @(negedge clk);
      testsRun++;
      if (wrEn !== 1'b0 || busy !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL reset_held: wr_en=%b busy=%b required 0 0", wrEn, busy);
      end
    end
    rstn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      testsRun++;
      if (busy !== 1'b0 || done !== 1'b0 || macClr !== 1'b0 || macEn !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL reset_idle: busy=%b done=%b mac_clr=%b mac_en=%b required all 0",
                 busy, done, macClr, macEn);
      end
    end
  endtask

  task automatic test_drain_stall();
    int cyc, macCnt, quiet;
    bit seenBias, gotWr;
    exp_t e;
    doReset();
    respDelay = 22;
    spurious  = 1'b1;
    start = 1'b1;
    cyc = 0; macCnt = 0; quiet = 0; seenBias = 1'b0; gotWr = 1'b0;
    while (!gotWr && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (macEn) macCnt++;
      if (wrEn) begin
        gotWr = 1'b1;
        testsRun++;
        if (!seenBias || expQ.size() == 0) begin
          testsFailed++;
          $display("[TB] FAIL stall_early_write: seen_bias=%0d queued=%0d required 1 1", seenBias, expQ.size());
        end else begin
          e = expQ.pop_front();
          if (wrData !== e.data || wrIdx !== e.idx) begin
            testsFailed++;
            $display("[TB] FAIL stall_write: data=%h idx=%0d required %h %0d", wrData, wrIdx, e.data, e.idx);
          end
        end
      end else if (seenBias) begin
        quiet++;
        testsRun++;
        if (macClr || macEn || biasEn || busy !== 1'b1) begin
          testsFailed++;
          $display("[TB] FAIL stall_strobes: clr=%b en=%b bias=%b busy=%b required 0 0 0 1",
                   macClr, macEn, biasEn, busy);
        end
      end
      if (biasEn) seenBias = 1'b1;
      respond();
    end
    spurious = 1'b0;
    testsRun++;
    if (!gotWr) begin
      testsFailed++;
      $display("[TB] FAIL stall_timeout: got no wr_en within %0d cycles", cyc);
    end
    testsRun++;
    if (quiet != 22 || macCnt != 784) begin
      testsFailed++;
      $display("[TB] FAIL stall_counts: drain=%0d mac=%0d required 22 784", quiet, macCnt);
    end
  endtask

  task automatic test_full_run();
    int cyc, doneCyc, wr0, wr1, expIn, nIn;
    bit seenBias;
    exp_t e;
    logic [3:0] expArg;
    logic expVld;
    doReset();
    respDelay = 2;
    start = 1'b1;
    cyc = 0; doneCyc = -1; wr0 = 0; wr1 = 0; expIn = 0; seenBias = 1'b0;
    while (doneCyc < 0 && cyc < 45000) begin
      @(negedge clk);
      cyc++;
      start = (cyc == 300);
      nIn = (expLayer == 0) ? 784 : 50;
      if (done === 1'b1) doneCyc = cyc;
      testsRun++;
      if (int'(macClr) + int'(macEn) + int'(biasEn) + int'(wrEn) > 1) begin
        testsFailed++;
        $display("[TB] FAIL strobe_exclusive: clr=%b en=%b bias=%b wr=%b required at most one",
                 macClr, macEn, biasEn, wrEn);
      end
      if (done !== 1'b1) begin
        testsRun++;
        if (busy !== 1'b1) begin
          testsFailed++;
          $display("[TB] FAIL busy_during_run: busy=%b required 1 at cycle %0d", busy, cyc);
        end
      end
      if (macClr) begin
        expIn = 0;
        testsRun++;
        if (inIdx !== 10'd0) begin
          testsFailed++;
          $display("[TB] FAIL clear_in_idx: in_idx=%0d required 0", inIdx);
        end
      end
      if (macEn) begin
        testsRun++;
        if (inIdx !== 10'(expIn) || macLast !== (expIn == nIn - 1) ||
            neuIdx !== 6'(expNeu) || layer !== 1'(expLayer)) begin
          testsFailed++;
          $display("[TB] FAIL mac_step: in=%0d last=%b neu=%0d layer=%b required %0d %b %0d %0d",
                   inIdx, macLast, neuIdx, layer, expIn, (expIn == nIn - 1), expNeu, expLayer);
          expIn = int'(inIdx);
        end
        expIn++;
      end
      if (biasEn) begin
        testsRun++;
        if (inIdx !== 10'd0 || expIn != nIn) begin
          testsFailed++;
          $display("[TB] FAIL bias_wrap: in_idx=%0d mac_count=%0d required 0 %0d", inIdx, expIn, nIn);
        end
        if (!seenBias) begin
          start = 1'b1;
          seenBias = 1'b1;
        end
      end
      if (wrEn) begin
        if (layer) wr1++; else wr0++;
        testsRun++;
        if (expQ.size() == 0) begin
          testsFailed++;
          $display("[TB] FAIL write_unexpected: idx=%0d data=%h with empty scoreboard", wrIdx, wrData);
        end else begin
          e = expQ.pop_front();
          if (wrIdx !== e.idx || wrData !== e.data || layer !== e.layer) begin
            testsFailed++;
            $display("[TB] FAIL write_data: layer=%b idx=%0d data=%h required %b %0d %h",
                     layer, wrIdx, wrData, e.layer, e.idx, e.data);
          end
        end
      end
      respond();
    end
    testsRun++;
    if (doneCyc != 40001) begin
      testsFailed++;
      $display("[TB] FAIL run_latency: done at cycle %0d required 40001", doneCyc);
    end
    testsRun++;
    if (wr0 != 50 || wr1 != 10 || expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL write_counts: layer0=%0d layer1=%0d left=%0d required 50 10 0", wr0, wr1, expQ.size());
    end
    testsRun++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL done_state: busy=%b done=%b required 0 1", busy, done);
    end
`ifdef ARGMAX_EN
    expArg = 4'd2; expVld = 1'b1;
`else
    expArg = 4'd0; expVld = 1'b0;
`endif
    testsRun++;
    if (argmax !== expArg || argmaxVld !== expVld) begin
      testsFailed++;
      $display("[TB] FAIL argmax: argmax=%0d vld=%b required %0d %b", argmax, argmaxVld, expArg, expVld);
    end
  endtask

  task automatic test_restart();
    repeat (3) begin
      @(negedge clk);
      testsRun++;
      if (done !== 1'b1 || busy !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL done_hold: done=%b busy=%b required 1 0", done, busy);
      end
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    testsRun++;
    if (done !== 1'b0 || busy !== 1'b1 || macClr !== 1'b1 || layer !== 1'b0 ||
        neuIdx !== 6'd0 || argmaxVld !== 1'b0 || argmax !== 4'd0) begin
      testsFailed++;
      $display("[TB] FAIL restart: done=%b busy=%b clr=%b layer=%b neu=%0d vld=%b arg=%0d required 0 1 1 0 0 0 0",
               done, busy, macClr, layer, neuIdx, argmaxVld, argmax);
    end
  endtask

  initial begin
    test_reset();
    test_drain_stall();
    test_full_run();
    test_restart();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
